// File: rtl/hs_arb_pkg.sv
// Shared definitions for the 4-client handshake arbiter: sizes, timeout default,
// FSM state encoding and the round-robin pick helper.
package hs_arb_pkg;

  localparam int ARB_NREQ = 4;
  localparam int ARB_TMO  = 255;
  localparam int CNT_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FWD  = 3'd1,
    ST_HOLD = 3'd2,
    ST_RTZ  = 3'd3,
    ST_ERR  = 3'd4
  } arb_state_e;

  // First set bit at or after ptr, wrapping 3->0; returns ptr when req is empty.
  function automatic logic [1:0] rr_pick(input logic [ARB_NREQ-1:0] req,
                                         input logic [1:0]          ptr);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < ARB_NREQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/hs_arbiter4_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, cleared by RST.
module sync2 (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/hs_arbiter4.sv
// Round-robin arbiter bridging four 4-phase clients onto one 4-phase shared
// datapath, with a sticky timeout error when the datapath stops answering.
module hs_arbiter4
  import hs_arb_pkg::*;
#(
  parameter int NREQ = ARB_NREQ,
  parameter int TMO  = ARB_TMO
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] REQ,
  output logic [NREQ-1:0] ACK,
  output logic            RES_REQ,
  input  logic            RES_ACK,
  output logic [1:0]      SEL,
  output logic            BUSY,
  output logic            ERR
);

  localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TMO);

  arb_state_e       state_q, state_d;
  logic [NREQ-1:0]  req_s;
  logic             res_ack_s;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             res_req_q, res_req_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             tmo_hit;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req_sync
    sync2 u_sync (
      .CLK (CLK),
      .RST (RST),
      .d   (REQ[gi]),
      .q   (req_s[gi])
    );
  end

  sync2 u_ack_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (RES_ACK),
    .q   (res_ack_s)
  );

  always_comb begin
    cnt_inc   = (cnt_q == TMO_C) ? cnt_q : cnt_q + 1'b1;
    tmo_hit   = (cnt_inc == TMO_C);
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    ack_d     = ack_q;
    res_req_d = res_req_q;
    err_d     = err_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (|req_s) begin
          sel_d     = rr_pick(req_s, ptr_q);
          res_req_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_FWD;
        end
      end
      ST_FWD: begin
        if (res_ack_s) begin
          ack_d   = NREQ'(1) << sel_q;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_inc;
          if (tmo_hit) state_d = ST_ERR;
        end
      end
      // Only the granted client's drop matters here; a client that dropped
      // early just makes this state last a single cycle.
      ST_HOLD: begin
        if (!req_s[sel_q]) begin
          res_req_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_RTZ;
        end
      end
      ST_RTZ: begin
        if (!res_ack_s) begin
          ack_d   = '0;
          ptr_d   = sel_q + 2'd1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (tmo_hit) state_d = ST_ERR;
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase

    // Entering or sitting in ERR parks both handshakes low until reset.
    if (state_d == ST_ERR) begin
      ack_d     = '0;
      res_req_d = 1'b0;
      err_d     = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      ack_q     <= '0;
      res_req_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      ack_q     <= ack_d;
      res_req_q <= res_req_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ACK     = ack_q;
  assign RES_REQ = res_req_q;
  assign SEL     = sel_q;
  assign ERR     = err_q;
  assign BUSY    = (state_q == ST_FWD) || (state_q == ST_HOLD) || (state_q == ST_RTZ);

endmodule
